// File: rtl/ysyx_23060240_lsu.sv
// ysyx_23060240_lsu: load/store unit that sits after decode. It runs one
// word-aligned transaction at a time on a req/ready data-memory port and
// returns the result to writeback on a valid/ready handshake.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          op handshake from decode
//   mem_rd_en, mem_wr_en         load / store enables (both set: load wins)
//   memory_rd_ctrl               1=lb 2=lbu 3=lh 4=lhu 5=lw (0/6/7 act as lw)
//   memory_wr_ctrl               1=sb 2=sh 3=sw (others: empty byte mask)
//   addr, wdata                  effective byte address, store data (rs2)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wmask         data-memory request, held stable in REQ
//   mem_ready, mem_rdata         memory accept/complete, read word
//   out_valid / out_ready        result handshake to writeback
//   rdata                        extended load result (0 for stores)
//   bus_err, misalign            error flags, qualified by out_valid
//
// Parameter MAX_WAIT: REQ cycles allowed without mem_ready before the op is
// aborted with bus_err; 0 disables the timeout.
//
// Optional macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half/word
// accesses skip memory and complete with misalign=1. When undefined,
// misalign is always 0 and such accesses use the truncated offsets.
module ysyx_23060240_lsu #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [2:0]  memory_rd_ctrl,
    input  logic [7:0]  memory_wr_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      state_q, state_d;
    logic        is_load_q;
    logic [2:0]  rd_ctrl_q;
    logic [1:0]  off_q;
    logic [31:0] wait_cnt_q;

    logic        accept;
    logic        mis;
    logic        timeout;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept  = (state_q == StIdle) && in_valid && (mem_rd_en || mem_wr_en);
    assign timeout = (MAX_WAIT != 0) && (wait_cnt_q == MAX_WAIT - 32'd1);

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        mis = 1'b0;
        if (mem_rd_en) begin
            case (memory_rd_ctrl)
                3'd1, 3'd2: mis = 1'b0;
                3'd3, 3'd4: mis = addr[0];
                default:    mis = |addr[1:0];
            endcase
        end else begin
            case (memory_wr_ctrl)
                8'd2:    mis = addr[0];
                8'd3:    mis = |addr[1:0];
                default: mis = 1'b0;
            endcase
        end
    end
`else
    assign mis = 1'b0;
`endif

    // Store byte strobes and lane-replicated data
    always_comb begin
        st_mask  = 4'b0000;
        st_wdata = wdata;
        case (memory_wr_ctrl)
            8'd1: begin
                st_mask  = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            8'd2: begin
                st_mask  = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            8'd3: st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    end

    // Load alignment and extension
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rd_ctrl_q)
            3'd1:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd2:    ld_data = {24'd0, ld_shift[7:0]};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = mis ? StResp : StReq;
            StReq:  if (mem_ready || timeout) state_d = StResp;
            StResp: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs; reset clears state asynchronously so these drop at once
    always_comb begin
        mem_req   = (state_q == StReq);
        out_valid = (state_q == StResp);
        in_ready  = (state_q == StIdle) && !rst;
    end

    // Request fields and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wmask  <= 4'd0;
            rdata      <= 32'd0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
            wait_cnt_q <= 32'd0;
            is_load_q  <= 1'b0;
            rd_ctrl_q  <= 3'd0;
            off_q      <= 2'd0;
        end else if (accept) begin
            mem_we     <= !mem_rd_en;
            mem_addr   <= {addr[31:2], 2'b00};
            mem_wdata  <= mem_rd_en ? 32'd0 : st_wdata;
            mem_wmask  <= mem_rd_en ? 4'd0 : st_mask;
            rdata      <= 32'd0;
            bus_err    <= 1'b0;
            misalign   <= mis;
            wait_cnt_q <= 32'd0;
            is_load_q  <= mem_rd_en;
            rd_ctrl_q  <= memory_rd_ctrl;
            off_q      <= addr[1:0];
        end else if (state_q == StReq) begin
            if (mem_ready) begin
                if (is_load_q) begin
                    rdata <= ld_data;
                end
            end else begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
                if (timeout) begin
                    bus_err <= 1'b1;
                    rdata   <= 32'd0;
                end
            end
        end
    end

endmodule
